// File: rtl/register_dump_engine.sv
// Register dump engine: walks a register range through one RF read port
// and streams each value out over valid/ready with a running XOR checksum.
module register_dump_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] firstReg,
  input  logic [ADDR_WIDTH-1:0] lastReg,
  output logic [ADDR_WIDTH-1:0] rfReadAddr,
  input  logic [DATA_WIDTH-1:0] rfReadData,
  output logic                  dumpValid,
  input  logic                  dumpReady,
  output logic [ADDR_WIDTH-1:0] dumpAddr,
  output logic [DATA_WIDTH-1:0] dumpData,
  output logic                  busy,
  output logic                  done,
  output logic                  rangeError,
  output logic [DATA_WIDTH-1:0] checksum
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    FINISH
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cursor_q;
  logic [ADDR_WIDTH-1:0] cursor_d;
  logic [ADDR_WIDTH-1:0] limit_q;
  logic [ADDR_WIDTH-1:0] rf_addr_q;
  logic [ADDR_WIDTH-1:0] dump_addr_q;
  logic [DATA_WIDTH-1:0] dump_data_q;
  logic [DATA_WIDTH-1:0] checksum_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  rerr_q;

  assign cursor_d = cursor_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      cursor_q    <= '0;
      limit_q     <= '0;
      rf_addr_q   <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      checksum_q  <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rerr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cursor_q   <= firstReg;
            limit_q    <= lastReg;
            checksum_q <= '0;
            busy_q     <= 1'b1;
            if (firstReg <= lastReg) begin
              rerr_q    <= 1'b0;
              rf_addr_q <= firstReg;
              state_q   <= READ;
            end else begin
              rerr_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= FINISH;
            end
          end
        end
        READ: begin
          dump_data_q <= rfReadData;
          dump_addr_q <= cursor_q;
          rf_addr_q   <= '0;
          valid_q     <= 1'b1;
          state_q     <= SEND;
        end
        SEND: begin
          if (dumpReady) begin
            valid_q    <= 1'b0;
            checksum_q <= checksum_q ^ dump_data_q;
            // compare before increment so a 0..max range never wraps
            if (cursor_q == limit_q) begin
              done_q  <= 1'b1;
              state_q <= FINISH;
            end else begin
              cursor_q  <= cursor_d;
              rf_addr_q <= cursor_d;
              state_q   <= READ;
            end
          end
        end
        FINISH: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rfReadAddr = rf_addr_q;
  assign dumpValid  = valid_q;
  assign dumpAddr   = dump_addr_q;
  assign dumpData   = dump_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign rangeError = rerr_q;
  assign checksum   = checksum_q;

endmodule

// File: tb/tb_register_dump_engine.sv
// Directed testbench for register_dump_engine: register file model,
// per-scenario tasks with inline checks against hand-computed values.
module tb_register_dump_engine;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic [4:0]  firstReg;
  logic [4:0]  lastReg;
  logic [4:0]  rfReadAddr;
  logic [31:0] rfReadData;
  logic        dumpValid;
  logic        dumpReady;
  logic [4:0]  dumpAddr;
  logic [31:0] dumpData;
  logic        busy;
  logic        done;
  logic        rangeError;
  logic [31:0] checksum;

  logic [31:0] rf [32];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  logic [4:0]  beat_a [$];
  logic [31:0] beat_d [$];
  int          done_off;
  int          valid_cyc;
  int          busy_cyc;
  int          unstable;
  logic        err_at_done;
  logic        busy_at_done;
  logic        timeout;

  register_dump_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk),
    .resetN(resetN),
    .start(start),
    .firstReg(firstReg),
    .lastReg(lastReg),
    .rfReadAddr(rfReadAddr),
    .rfReadData(rfReadData),
    .dumpValid(dumpValid),
    .dumpReady(dumpReady),
    .dumpAddr(dumpAddr),
    .dumpData(dumpData),
    .busy(busy),
    .done(done),
    .rangeError(rangeError),
    .checksum(checksum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rfReadData = rf[rfReadAddr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic zero);
    for (int n = 0; n < 32; n++)
      rf[n] = zero ? 32'h0 : 32'h1000_0000 + 32'(n);
  endtask

  // Runs one dump and records what the sink saw; returns in the done cycle.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                          input int stall, input int pulse_at);
    int k;
    int vseen;
    logic pulsed;
    logic hold;
    logic [4:0] ha;
    logic [31:0] hd;
    beat_a.delete();
    beat_d.delete();
    done_off = -1;
    valid_cyc = 0;
    busy_cyc = 0;
    unstable = 0;
    err_at_done = 1'b0;
    busy_at_done = 1'b0;
    timeout = 1'b0;
    vseen = 0;
    pulsed = 1'b0;
    hold = 1'b0;
    ha = '0;
    hd = '0;
    start = 1'b1;
    firstReg = f;
    lastReg = l;
    step();
    k = cyc;
    start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin
        done_off = cyc - k;
        err_at_done = rangeError;
        busy_at_done = busy;
        return;
      end
      if (busy) busy_cyc++;
      dumpReady = (vseen >= stall);
      if (dumpValid) begin
        if (!hold) begin
          ha = dumpAddr;
          hd = dumpData;
          hold = 1'b1;
        end else if (dumpAddr !== ha || dumpData !== hd) begin
          unstable++;
        end
        vseen++;
        valid_cyc++;
        if (!pulsed && pulse_at > 0 && beat_a.size() == pulse_at - 1) begin
          start = 1'b1;
          firstReg = 5'd5;
          lastReg = 5'd6;
          pulsed = 1'b1;
        end
        if (dumpReady) begin
          beat_a.push_back(dumpAddr);
          beat_d.push_back(dumpData);
          hold = 1'b0;
        end
      end
      step();
      start = 1'b0;
    end
    timeout = 1'b1;
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    start = 1'b0;
    firstReg = '0;
    lastReg = '0;
    dumpReady = 1'b0;
    preload(1'b1);
    step();
    step();
    total++;
    if ({dumpValid, busy, done, rangeError} !== 4'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000",
               {dumpValid, busy, done, rangeError});
    end
    total++;
    if ({rfReadAddr, dumpAddr, dumpData, checksum} !== 74'h0) begin
      bad++;
      $display("FAIL reset_values got=%h want=0",
               {rfReadAddr, dumpAddr, dumpData, checksum});
    end
    #3 resetN = 1'b1;
    step();
    total++;
    if ({busy, dumpValid, rfReadAddr} !== 7'h0) begin
      bad++;
      $display("FAIL idle_after_reset got=%h want=0",
               {busy, dumpValid, rfReadAddr});
    end
  endtask

  task automatic test_zeros_full();
    int errs;
    preload(1'b1);
    dumpReady = 1'b1;
    run_dump(5'd0, 5'd31, 0, 0);
    total++;
    if (timeout !== 1'b0) begin
      bad++;
      $display("FAIL zeros_timeout got=%b want=0", timeout);
    end
    total++;
    if (beat_a.size() != 32) begin
      bad++;
      $display("FAIL zeros_beats got=%0d want=32", beat_a.size());
    end
    errs = 0;
    for (int i = 0; i < beat_a.size(); i++)
      if (beat_a[i] !== 5'(i) || beat_d[i] !== 32'h0) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL zeros_seq got=%0d_bad want=0", errs);
    end
    total++;
    if (done_off != 64) begin
      bad++;
      $display("FAIL zeros_done_cycle got=%0d want=64", done_off);
    end
    total++;
    if (checksum !== 32'h0) begin
      bad++;
      $display("FAIL zeros_checksum got=%h want=00000000", checksum);
    end
    step();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL zeros_idle got=%b want=0", busy);
    end
  endtask

  task automatic test_range_3_5();
    preload(1'b0);
    run_dump(5'd3, 5'd5, 0, 0);
    total++;
    if (beat_a.size() != 3) begin
      bad++;
      $display("FAIL r35_beats got=%0d want=3", beat_a.size());
    end
    for (int i = 0; i < beat_a.size() && i < 3; i++) begin
      total++;
      if (beat_a[i] !== 5'(i + 3) || beat_d[i] !== 32'h1000_0003 + 32'(i)) begin
        bad++;
        $display("FAIL r35_beat%0d got=%0d/%h want=%0d/%h", i, beat_a[i],
                 beat_d[i], i + 3, 32'h1000_0003 + 32'(i));
      end
    end
    total++;
    if (checksum !== 32'h1000_0002) begin
      bad++;
      $display("FAIL r35_checksum got=%h want=10000002", checksum);
    end
    total++;
    if (done_off != 6 || busy_at_done !== 1'b1) begin
      bad++;
      $display("FAIL r35_done got=%0d/%b want=6/1", done_off, busy_at_done);
    end
    step();
  endtask

  task automatic test_stall();
    preload(1'b0);
    run_dump(5'd7, 5'd7, 4, 0);
    dumpReady = 1'b1;
    total++;
    if (valid_cyc != 5 || unstable != 0) begin
      bad++;
      $display("FAIL stall_hold got=%0d/%0d want=5/0", valid_cyc, unstable);
    end
    total++;
    if (beat_a.size() != 1) begin
      bad++;
      $display("FAIL stall_beats got=%0d want=1", beat_a.size());
    end else begin
      total++;
      if (beat_a[0] !== 5'd7 || beat_d[0] !== 32'h1000_0007) begin
        bad++;
        $display("FAIL stall_beat got=%0d/%h want=7/10000007",
                 beat_a[0], beat_d[0]);
      end
    end
    total++;
    if (done_off != 6) begin
      bad++;
      $display("FAIL stall_done got=%0d want=6", done_off);
    end
    total++;
    if (checksum !== 32'h1000_0007) begin
      bad++;
      $display("FAIL stall_checksum got=%h want=10000007", checksum);
    end
    step();
  endtask

  task automatic test_range_error();
    preload(1'b0);
    run_dump(5'd9, 5'd2, 0, 0);
    total++;
    if (done_off != 0 || err_at_done !== 1'b1 || busy_at_done !== 1'b1) begin
      bad++;
      $display("FAIL rerr_done got=%0d/%b/%b want=0/1/1", done_off,
               err_at_done, busy_at_done);
    end
    total++;
    if (valid_cyc != 0 || checksum !== 32'h0) begin
      bad++;
      $display("FAIL rerr_no_beats got=%0d/%h want=0/0", valid_cyc, checksum);
    end
    // start in the FINISH cycle must be dropped
    start = 1'b1;
    firstReg = 5'd4;
    lastReg = 5'd6;
    step();
    start = 1'b0;
    total++;
    if (busy !== 1'b0 || rangeError !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL rerr_after got=%b/%b/%b want=0/1/0",
               busy, rangeError, done);
    end
    run_dump(5'd1, 5'd1, 0, 0);
    total++;
    if (rangeError !== 1'b0 || beat_a.size() != 1) begin
      bad++;
      $display("FAIL rerr_clear got=%b/%0d want=0/1", rangeError,
               beat_a.size());
    end else begin
      total++;
      if (beat_d[0] !== 32'h1000_0001 || done_off != 2) begin
        bad++;
        $display("FAIL rerr_next_beat got=%h/%0d want=10000001/2",
                 beat_d[0], done_off);
      end
    end
    step();
  endtask

  task automatic test_start_while_busy();
    int errs;
    logic [31:0] exp_ck;
    preload(1'b0);
    exp_ck = 32'h0;
    for (int n = 0; n < 32; n++) exp_ck ^= 32'h1000_0000 + 32'(n);
    run_dump(5'd0, 5'd31, 0, 10);
    total++;
    if (beat_a.size() != 32 || done_off != 64) begin
      bad++;
      $display("FAIL busy_start_beats got=%0d/%0d want=32/64",
               beat_a.size(), done_off);
    end
    errs = 0;
    for (int i = 0; i < beat_a.size(); i++)
      if (beat_a[i] !== 5'(i) || beat_d[i] !== 32'h1000_0000 + 32'(i)) errs++;
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL busy_start_seq got=%0d_bad want=0", errs);
    end
    total++;
    if (checksum !== exp_ck) begin
      bad++;
      $display("FAIL busy_start_checksum got=%h want=%h", checksum, exp_ck);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int errs;
    preload(1'b0);
    dumpReady = 1'b1;
    start = 1'b1;
    firstReg = 5'd0;
    lastReg = 5'd3;
    step();
    start = 1'b0;
    step();
    step();
    step();
    total++;
    if (dumpValid !== 1'b1 || dumpAddr !== 5'd1 || checksum !== 32'h1000_0000) begin
      bad++;
      $display("FAIL mid_pre got=%b/%0d/%h want=1/1/10000000",
               dumpValid, dumpAddr, checksum);
    end
    resetN = 1'b0;
    #1;
    total++;
    if ({dumpValid, busy, done, rangeError, rfReadAddr, dumpAddr, dumpData,
         checksum} !== 78'h0) begin
      bad++;
      $display("FAIL mid_async_clear got=%h want=0", {dumpValid, busy, done,
               rangeError, rfReadAddr, dumpAddr, dumpData, checksum});
    end
    errs = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (done !== 1'b0 || dumpValid !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL mid_no_done got=%0d want=0", errs);
    end
    #3 resetN = 1'b1;
    step();
    run_dump(5'd0, 5'd3, 0, 0);
    errs = 0;
    for (int i = 0; i < beat_a.size(); i++)
      if (beat_a[i] !== 5'(i) || beat_d[i] !== 32'h1000_0000 + 32'(i)) errs++;
    total++;
    if (beat_a.size() != 4 || errs != 0 || done_off != 8) begin
      bad++;
      $display("FAIL mid_rerun got=%0d/%0d/%0d want=4/0/8",
               beat_a.size(), errs, done_off);
    end
    total++;
    if (checksum !== 32'h0) begin
      bad++;
      $display("FAIL mid_checksum got=%h want=00000000", checksum);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_zeros_full();
    test_range_3_5();
    test_stall();
    test_range_error();
    test_start_while_busy();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_dump_engine.md
Name: register_dump_engine

Overview:
- Read-side companion to the register file write port: walks a contiguous range of architectural registers through one register-file read port and streams each value out over a valid/ready interface.
- Sits beside the single-cycle core. Drives the register file's source-register address and captures its combinational read data.
- Feeds a debug/trace sink and produces an XOR checksum of the streamed values.

Parameters:
- DATA_WIDTH, 32, width of register values and of dumpData/checksum.
- ADDR_WIDTH, 5, width of register addresses.

Ports:
- clk  input  1  rising-edge clock.
- resetN  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- firstReg  input  ADDR_WIDTH  first register index; latched on accepted start.
- lastReg  input  ADDR_WIDTH  last register index, inclusive; latched on accepted start.
- rfReadAddr  output  ADDR_WIDTH  address driven to the register file read port.
- rfReadData  input  DATA_WIDTH  combinational read data for rfReadAddr.
- dumpValid  output  1  stream beat valid.
- dumpReady  input  1  sink ready.
- dumpAddr  output  ADDR_WIDTH  register index of the current beat.
- dumpData  output  DATA_WIDTH  register value of the current beat.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a dump finishes.
- rangeError  output  1  set with done when firstReg > lastReg; cleared on the next accepted start.
- checksum  output  DATA_WIDTH  XOR of all dumpData values transferred in the current or most recent dump.

Behaviour:
- Reset (async assert, sync deassert-safe) sets every output to 0, state to IDLE, and internal cursor/limit to 0.
- States: IDLE, READ, SEND, FINISH.
- IDLE:
  - rfReadAddr = 0.
  - start=1 latches firstReg into cursor and lastReg into limit, clears checksum and rangeError.
  - Next state is READ if firstReg <= lastReg.
  - Otherwise next state is FINISH with rangeError set and zero beats sent.
- READ (exactly 1 cycle):
  - rfReadAddr = cursor.
  - At the clock edge, captures rfReadData into the dumpData holding register and cursor into dumpAddr.
  - Next state is SEND.
- SEND:
  - dumpValid=1. dumpAddr and dumpData are held stable until the handshake.
  - Handshake is dumpValid & dumpReady at a rising edge.
  - On handshake: checksum ^= dumpData.
  - After the handshake, next state is FINISH if cursor == limit. Otherwise cursor increments and next state is READ.
  - With dumpReady=0, the engine stalls indefinitely with no change to any output.
- FINISH (1 cycle): done=1, busy=1, dumpValid=0. Next state is IDLE.
- Latency and throughput:
  - start accepted at edge k: READ occupies cycle k+1 and dumpValid first rises in cycle k+2.
  - With dumpReady tied high, each beat takes 2 cycles.
  - An N-register dump asserts done in cycle k+2N+1.
- Boundary conditions:
  - firstReg == lastReg gives exactly one beat.
  - Range 0..31 gives 32 beats. The cursor compare against limit happens before the increment, so 31 never wraps to 0.
  - Register 0 is dumped like any other register, with no special-casing; its value comes from the register file.
- Simultaneous events:
  - start while busy is ignored and has no effect on latched range or checksum.
  - start asserted in the FINISH cycle is ignored.
  - start in the first IDLE cycle after FINISH is accepted.
- Reset mid-operation returns to IDLE immediately: dumpValid drops without a handshake, checksum clears, and no done pulse occurs.
- checksum and rangeError are stable from FINISH until the next accepted start.

Test Plan:
- Reset, then model register file with all zeros; start, range 0..31, dumpReady=1 -> 32 beats, addr 0..31, data 0, done in cycle k+65, checksum 0x00000000.
- Register file preloaded with regN = 0x1000_0000+N; range 3..5, dumpReady=1 -> beats (3,0x10000003),(4,0x10000004),(5,0x10000005), checksum 0x10000002, done one cycle after the 3rd handshake.
- Same preload, range 7..7; dumpReady low for 4 cycles then high -> dumpValid held for 5 cycles with addr 7 / data 0x10000007 stable, single beat, done next cycle.
- firstReg=9, lastReg=2 -> no dumpValid, done and rangeError high in cycle k+1, busy high only that cycle; a following start with 1..1 clears rangeError.
- Range 0..31 with start pulsed again at the 10th beat -> ignored, beat sequence unchanged, 32 beats total.
- resetN pulsed low during the SEND of the 2nd beat of range 0..3 -> all outputs 0 asynchronously, no done pulse; a new start 0..3 produces 4 clean beats.
